// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encodings, parity modes and baud divisor helper.
// Used by both the transmit serializer and the planned receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clocks per bit, truncated toward zero.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter; tick marks the last clock of each bit period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one byte per tx_start/tx_ready handshake and sends
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_o
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end

    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        clr_c;
    logic        tick;

    // Counter is held at zero while idle so each frame starts on a fresh bit period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr_c),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-output logic; line changes only on bit boundaries.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        clr_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clr_c   = 1'b1;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (tx_start_i) begin
                    shift_d    = tx_data_i;
                    parity_d   = (PARITY == PAR_EVEN) ? ^tx_data_i : ~^tx_data_i;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    ready_d    = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = ready_q;
    assign tx_done_o  = done_q;

endmodule
